// File: rtl/full_adder.sv
// Single-bit full adder cell: Sum = A ^ B ^ C, Carry = majority(A, B, C).
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Sum,
    output logic Carry
);

    // Purely combinational sum and carry
    assign Sum   = A ^ B ^ C;
    assign Carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Two WIDTH-bit operands are captured on an
// accepted start, then fed LSB-first through one full_adder cell, one bit
// per clock, with the carry held in a flop between bits. Sum bits are
// shifted in at the MSB of a partial-sum register, so after WIDTH steps
// the register holds the complete result. {Cout, Sum} == A + B + Cin.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sha_reg;
    logic [WIDTH-1:0] shb_reg;
    logic [WIDTH-1:0] psum_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] sha_next;
    logic [WIDTH-1:0] shb_next;
    logic [WIDTH-1:0] psum_next;
    logic             fa_sum;
    logic             fa_carry;

    // The one shared adder cell: current operand LSBs plus the stored carry
    full_adder u_fa (
        .A     (sha_reg[0]),
        .B     (shb_reg[0]),
        .C     (carry_reg),
        .Sum   (fa_sum),
        .Carry (fa_carry)
    );

    // Right-shift networks: operands zero-fill, partial sum takes the new bit at the MSB
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign sha_next[gi]  = sha_reg[gi+1];
            assign shb_next[gi]  = shb_reg[gi+1];
            assign psum_next[gi] = psum_reg[gi+1];
        end
    endgenerate

    assign sha_next[WIDTH-1]  = 1'b0;
    assign shb_next[WIDTH-1]  = 1'b0;
    assign psum_next[WIDTH-1] = fa_sum;

    // Control FSM with datapath registers and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sha_reg   <= '0;
            shb_reg   <= '0;
            psum_reg  <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        sha_reg   <= A;
                        shb_reg   <= B;
                        carry_reg <= Cin;
                        psum_reg  <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sha_reg   <= sha_next;
                    shb_reg   <= shb_next;
                    psum_reg  <= psum_next;
                    carry_reg <= fa_carry;
                    if (cnt_reg == LAST_BIT) begin
                        // Last bit: publish the result; counter is left as-is so it never wraps
                        sum_reg   <= psum_next;
                        cout_reg  <= fa_carry;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;

endmodule
